seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
Time-multiplexing scan controller for a bank of NUM_DIGITS common-select 7-segment digits that share one bcd2led7seg decode/PWM datapath.
- Holds a double-buffered digit value bank.
- Presents one BCD nibble at a time on bcd_out, with a one-hot digit select.
- Inserts a blanking gap between digits to prevent ghosting.
- Applies leading-zero suppression.
- Sits between the traffic-light timer/countdown logic (producer) and the bcd2led7seg instance plus digit driver pins.

Parameters:
CLK_FREQ, 125_000_000, input clock frequency in Hz
SCAN_FREQ, 1000, full-frame refresh rate in Hz (all digits once)
NUM_DIGITS, 4, number of multiplexed digits (2..8)
BLANK_CYCLES, 64, all-digits-off cycles between consecutive digit slots
(derived) SLOT_CYCLES = CLK_FREQ/(SCAN_FREQ*NUM_DIGITS); SHOW_CYCLES = SLOT_CYCLES-BLANK_CYCLES; elaboration error if SHOW_CYCLES < 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; 0 forces idle with all digits off
digits_in  in  4*NUM_DIGITS  BCD digits; nibble 0 = least significant
load_valid  in  1  producer offers digits_in
load_ready  out  1  controller can accept a new digit set
lz_suppress  in  1  1 = blank leading zeros
bcd_out  out  4  BCD nibble to bcd2led7seg bcd_input
digit_en  out  NUM_DIGITS  one-hot active-high digit select; all-zero = dark
frame_start  out  1  one-cycle pulse at the start of digit-0 slot

Behaviour:
- Reset values:
  - Outputs: bcd_out=0, digit_en=0, frame_start=0, load_ready=1.
  - Internal: state=S_IDLE, index=0, slot counter=0, shadow=0, active=0, pending=0.
- FSM states: S_IDLE, S_SHOW, S_BLANK.
  - S_IDLE: if enable, go to S_SHOW with index=0 on the next cycle.
  - S_SHOW: lasts exactly SHOW_CYCLES, then goes to S_BLANK.
  - S_BLANK: lasts exactly BLANK_CYCLES, then index advances (NUM_DIGITS-1 wraps to 0) and the FSM goes to S_SHOW.
  - From any state, enable=0: go to S_IDLE next cycle and clear index and counter.
  - After re-enable, scanning always restarts at digit 0.
- Outputs are registered and update on the same edge as the state register.
  - In S_SHOW for index k, not suppressed: digit_en = 1<<k and bcd_out = active[k].
  - In S_BLANK, S_IDLE, or a suppressed/invalid slot: digit_en=0 and bcd_out holds its last value.
- frame_start is 1 for exactly the first cycle of each S_SHOW with index 0, including the first after leaving S_IDLE.
- Load handshake and commit:
  - load_ready = !pending.
  - Transfer occurs when load_valid && load_ready: digits_in is captured into shadow and pending is set.
  - Shadow commits to active, and pending clears, on the cycle the FSM enters S_SHOW with index 0, or on the cycle after capture if in S_IDLE. Displayed digits therefore never change mid-frame.
  - Back-to-back loads: the second transfer stalls (load_ready=0) until the commit. load_valid may stay high.
- Leading-zero suppression (evaluated on active):
  - Digit i (i≥1) is suppressed when lz_suppress=1 and active[NUM_DIGITS-1..i] are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Invalid nibble (>9) in active: that slot is dark (digit_en=0). Slot timing is unchanged.
- Reset mid-frame or mid-handshake: all state returns to reset values and any pending shadow is discarded.

Decomposition:
- Package seg7_scan_pkg: typedef enum logic [1:0] scan_state_t {S_IDLE, S_SHOW, S_BLANK}; localparam BCD_MAX=4'd9; function lz_mask(active, n) returning the suppression vector.
- Sub-module seg7_slot_timer: loadable down-counter with a terminal-count pulse. It is reused for both SHOW and BLANK durations, and its width is $clog2(max(SHOW_CYCLES,BLANK_CYCLES)+1).

Test Plan (CLK_FREQ=8000, SCAN_FREQ=100, NUM_DIGITS=4, BLANK_CYCLES=4 → SHOW_CYCLES=16):
1. Reset, enable=1, load 0x4321, lz_suppress=0 → frame_start pulses every 80 cycles; digit_en sequence is 0001,0000,0010,0000,0100,0000,1000,0000 with run lengths 16/4; bcd_out is 1,2,3,4 during the respective SHOW windows.
2. Load 0x0042, lz_suppress=1 → digits 3 and 2 stay dark for their whole slots; digit 1 shows 4 and digit 0 shows 2. Load 0x0000 → only digit 0 lit, showing 0.
3. Load 0x1111 mid-frame (cycle 30 of frame) → display keeps the old value until the next frame_start and switches exactly on that cycle; load_ready is 0 from capture until commit. A second load_valid in that window is not accepted.
4. enable dropped during digit-2 SHOW → digit_en=0 from the next cycle. Re-enable → frame_start fires and digit 0 shows first.
5. Nibble 0xA at digit 1 → digit 1 slot is dark while other digits display normally and slot timing is unchanged.
6. reset asserted with pending=1 → load_ready=1, digit_en=0, and after re-enable all digits show 0.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// lz_mask marks which digit positions are leading zeros of the active value.
package seg7_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_BLANK
  } scan_state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Bit i is set when nibbles n-1..i are all zero (i >= 1).
  // Digit 0 is never marked, so a value of zero still shows one "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] active,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        upper_zero = upper_zero & (active[4*i +: 4] == 4'd0);
        mask[i]    = upper_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Producer-to-controller load handshake for the scan controller's digit bank.
interface seg7_scan_controller_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load_valid;
  logic                    load_ready;

  modport master (
    output digits_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  digits_in,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/seg7_scan_controller_slot_timer.sv
// Loadable down-counter shared by SHOW and BLANK windows.
// tc is high while the count sits at zero, i.e. the last cycle of a window.
module seg7_slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS BCD digits with blanking gaps,
// double-buffered digit bank committed only at frame boundaries.
import seg7_scan_pkg::*;

module seg7_scan_controller #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int SCAN_FREQ    = 1000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  seg7_scan_controller_if.slave   ld,
  input  logic                    lz_suppress,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int SLOT_CYCLES = CLK_FREQ / (SCAN_FREQ * NUM_DIGITS);
  localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int MAX_CYCLES  = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int TW          = $clog2(MAX_CYCLES + 1);
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_DIGITS - 1);

  generate
    if (SHOW_CYCLES < 1) begin : g_bad_show
      $error("seg7_scan_controller: slot too short for BLANK_CYCLES");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("seg7_scan_controller: NUM_DIGITS must be 2..8");
    end
  endgenerate

  scan_state_t             state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [3:0]              bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_start_q, frame_start_d;

  logic          tmr_clear;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_tc;
  logic          enter_frame;
  logic          transfer;
  logic          commit;

  seg7_slot_timer #(.W(TW)) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  // State register (also holds the datapath and registered outputs).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      bcd_out_q     <= '0;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      bcd_out_q     <= bcd_out_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state logic and slot timer control.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = SHOW_LOAD;
    if (!enable) begin
      state_d   = S_IDLE;
      index_d   = '0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_SHOW;
          index_d  = '0;
          tmr_load = 1'b1;
        end
        S_SHOW: begin
          if (tmr_tc) begin
            state_d   = S_BLANK;
            tmr_load  = 1'b1;
            tmr_value = BLANK_LOAD;
          end
        end
        S_BLANK: begin
          if (tmr_tc) begin
            state_d  = S_SHOW;
            index_d  = (index_q == LAST_INDEX) ? '0 : index_q + IW'(1);
            tmr_load = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign enter_frame = (state_d == S_SHOW) && (state_q != S_SHOW) && (index_d == '0);

  // Double buffer: a capture waits in shadow until the next frame boundary,
  // or is taken straight away while the display is idle.
  always_comb begin
    transfer  = ld.load_valid && !pending_q;
    commit    = pending_q && (enter_frame || state_q == S_IDLE);
    shadow_d  = transfer ? ld.digits_in : shadow_q;
    active_d  = commit ? shadow_q : active_q;
    pending_d = transfer || (pending_q && !commit);
  end

  // Output logic, decided from the value that will be active on the same edge.
  logic [4*MAX_DIGITS-1:0] active_wide;
  logic [MAX_DIGITS-1:0]   lz_vec;
  logic [3:0]              nibble;
  logic                    suppressed;

  always_comb begin
    active_wide                   = '0;
    active_wide[4*NUM_DIGITS-1:0] = active_d;
    lz_vec                        = lz_mask(active_wide, NUM_DIGITS);
    nibble                        = active_d[4*index_d +: 4];
    suppressed                    = lz_suppress && lz_vec[index_d];
    digit_en_d                    = '0;
    bcd_out_d                     = bcd_out_q;
    frame_start_d                 = enter_frame;
    if (state_d == S_SHOW && !suppressed && nibble <= BCD_MAX) begin
      digit_en_d = NUM_DIGITS'(1) << index_d;
      bcd_out_d  = nibble;
    end
  end

  assign ld.load_ready = !pending_q;
  assign bcd_out       = bcd_out_q;
  assign digit_en      = digit_en_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed/random bench: a frame-position model predicts every output cycle.
module tb_seg7_scan_controller;

  localparam int N     = 4;
  localparam int SLOT  = 20;
  localparam int SHOW  = 16;
  localparam int FRAME = N * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       lz_suppress;
  logic [3:0] bcd_out;
  logic [N-1:0] digit_en;
  logic       frame_start;

  seg7_scan_controller_if #(.NUM_DIGITS(N)) ld_if ();

  seg7_scan_controller #(
    .CLK_FREQ     (8000),
    .SCAN_FREQ    (100),
    .NUM_DIGITS   (N),
    .BLANK_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ld          (ld_if),
    .lz_suppress (lz_suppress),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] m_bcd;
  logic [15:0] cur;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A slot is lit unless its nibble is not BCD, or it is a leading zero.
  function automatic logic slot_lit(input logic [15:0] act, input logic lz, input int s);
    logic [15:0] upper;
    upper = act >> (4 * s);
    if ((upper & 16'hF) > 16'd9) return 1'b0;
    if (lz && s > 0 && upper == 16'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_frame();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_start === 1'b1) break;
    end
    chk("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  // Starts at the sample showing frame_start; checks every cycle of the frame.
  task automatic run_frame(input logic [15:0] act, input logic lz, input int load_pos,
                           input logic [15:0] load_val, input logic [15:0] sec_val,
                           input int stop_pos);
    int   slot;
    int   off;
    logic lit;
    lz_suppress = lz;
    for (int pos = 0; pos < FRAME; pos++) begin
      slot = pos / SLOT;
      off  = pos % SLOT;
      lit  = (off < SHOW) && slot_lit(act, lz, slot);
      if (lit) m_bcd = 4'((act >> (4 * slot)) & 16'hF);
      chk("frame_start", 32'(frame_start), 32'(pos == 0));
      chk("digit_en", 32'(digit_en), lit ? (32'd1 << slot) : 32'd0);
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("load_ready", 32'(ld_if.load_ready), 32'(!(load_pos >= 0 && pos > load_pos)));
      if (pos == stop_pos) return;
      if (load_pos >= 0 && pos == load_pos) begin
        ld_if.load_valid = 1'b1;
        ld_if.digits_in  = load_val;
      end else if (load_pos >= 0 && pos == load_pos + 1) begin
        ld_if.digits_in = sec_val;
      end
      if (pos == FRAME - 1) ld_if.load_valid = 1'b0;
      tick();
    end
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    logic [15:0] nv;
    reset            = 1'b1;
    enable           = 1'b0;
    lz_suppress      = 1'b0;
    ld_if.load_valid = 1'b0;
    ld_if.digits_in  = '0;
    m_bcd            = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_load_ready", 32'(ld_if.load_ready), 32'd1);

    // Load while idle: capture then commit on the following cycle.
    ld_if.load_valid = 1'b1;
    ld_if.digits_in  = 16'h4321;
    tick();
    chk("idle_capture_ready", 32'(ld_if.load_ready), 32'd0);
    ld_if.load_valid = 1'b0;
    tick();
    chk("idle_commit_ready", 32'(ld_if.load_ready), 32'd1);
    chk("idle_dark", 32'(digit_en), 32'd0);

    enable = 1'b1;
    wait_frame();
    run_frame(16'h4321, 1'b0, 30, 16'h0042, 16'($urandom), FRAME);
    run_frame(16'h0042, 1'b1, $urandom_range(0, 78), 16'h0000, 16'($urandom), FRAME);
    run_frame(16'h0000, 1'b1, 30, 16'h1111, 16'($urandom), FRAME);
    nv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'hA, 4'($urandom_range(0, 9))};
    run_frame(16'h1111, 1'b0, $urandom_range(0, 78), nv, 16'($urandom), FRAME);
    cur = nv;
    for (int f = 0; f < 6; f++) begin
      nv = rand_val();
      run_frame(cur, 1'($urandom_range(0, 1)), $urandom_range(0, 78), nv, 16'($urandom), FRAME);
      cur = nv;
    end

    // Drop enable in the middle of digit 2's show window.
    run_frame(cur, 1'b0, -1, 16'h0, 16'h0, 45);
    enable = 1'b0;
    tick();
    chk("disable_dark", 32'(digit_en), 32'd0);
    chk("disable_no_frame", 32'(frame_start), 32'd0);
    chk("disable_bcd_hold", 32'(bcd_out), 32'(m_bcd));
    repeat (3) begin
      tick();
      chk("idle_stays_dark", 32'(digit_en), 32'd0);
    end
    enable = 1'b1;
    wait_frame();
    run_frame(cur, 1'b0, -1, 16'h0, 16'h0, FRAME);

    // Reset with a load pending: the shadow value must be discarded.
    run_frame(cur, 1'b0, 10, 16'h9876, 16'h5555, 20);
    ld_if.load_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst2_load_ready", 32'(ld_if.load_ready), 32'd1);
    chk("rst2_digit_en", 32'(digit_en), 32'd0);
    chk("rst2_bcd", 32'(bcd_out), 32'd0);
    chk("rst2_frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    m_bcd = '0;
    wait_frame();
    run_frame(16'h0000, 1'b0, -1, 16'h0, 16'h0, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
